alarm_annunciator: RTL and testbench

Output sequencer for the alarm clock: owns the buzzer pin and the seven-segment display enable. It converts the alarm controller's level outputs (`buzzer_on`, `display_flash`) into a gated tone with an on/off beep cadence, a blinking display enable, user acknowledge and an automatic silence timeout. It sits between `alarmController` and the buzzer pin / `sevenSegDisplay` display-enable input in `alarmclock_top`.

---
 rtl/alarm_annunciator.sv | 171 +++++++++++++++++
 tb/tb_alarm_annunciator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_annunciator.sv
// alarm_annunciator
//   Output sequencer for the alarm clock. Turns the alarm controller's level
//   outputs into a gated, beeping buzzer tone and a blinking display enable,
//   with user acknowledge and automatic silence after a ringing timeout.
//
// Ports
//   clk         base clock (only clock)
//   reset_b     asynchronous active-low reset
//   alarm       alarm-expired level from the alarm controller
//   flash_req   display-flash level from the alarm controller
//   ack         single-cycle debounced acknowledge pulse
//   fast        1 halves the cadence tick period
//   buzzer      registered tone output to the buzzer pin
//   display_on  registered seven-segment display enable
//   state       FSM state: 00 IDLE, 01 BEEP_ON, 10 BEEP_OFF, 11 SILENCED
module alarm_annunciator #(
  parameter int TONE_DIV       = 12500,
  parameter int CADENCE_DIV    = 5000000,
  parameter int BEEP_ON_TICKS  = 3,
  parameter int BEEP_OFF_TICKS = 2,
  parameter int SILENCE_TICKS  = 300,
  parameter int FLASH_TICKS    = 5
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       alarm,
  input  logic       flash_req,
  input  logic       ack,
  input  logic       fast,
  output logic       buzzer,
  output logic       display_on,
  output logic [1:0] state
);

  localparam int PH_MAX = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
  localparam int PRE_W  = $clog2(CADENCE_DIV) + 1;
  localparam int PH_W   = $clog2(PH_MAX) + 1;
  localparam int TO_W   = $clog2(SILENCE_TICKS) + 1;
  localparam int TN_W   = $clog2(TONE_DIV) + 1;
  localparam int BL_W   = $clog2(FLASH_TICKS) + 1;

  localparam logic [PRE_W-1:0] TERM_SLOW = PRE_W'(CADENCE_DIV - 1);
  localparam logic [PRE_W-1:0] TERM_FAST = PRE_W'(CADENCE_DIV / 2 - 1);
  localparam logic [PH_W-1:0]  ON_T      = PH_W'(BEEP_ON_TICKS);
  localparam logic [PH_W-1:0]  OFF_T     = PH_W'(BEEP_OFF_TICKS);
  localparam logic [TO_W-1:0]  SIL_T     = TO_W'(SILENCE_TICKS);
  localparam logic [TN_W-1:0]  TONE_T    = TN_W'(TONE_DIV - 1);
  localparam logic [BL_W-1:0]  FLASH_T   = BL_W'(FLASH_TICKS);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BEEP_ON  = 2'b01,
    BEEP_OFF = 2'b10,
    SILENCED = 2'b11
  } state_t;

  state_t            cur;
  logic [PRE_W-1:0]  presc;
  logic [PH_W-1:0]   phase;
  logic [TO_W-1:0]   timeout;
  logic [TN_W-1:0]   tone_cnt;
  logic [BL_W-1:0]   blink;

  logic              tick;
  logic              in_beep;
  logic              timeout_done;
  logic [PH_W-1:0]   phase_inc;
  logic [TO_W-1:0]   timeout_inc;
  logic [BL_W-1:0]   blink_inc;

  assign state = cur;

  // >= compare lets a mid-count switch to fast tick on the very next cycle.
  assign tick    = (presc >= (fast ? TERM_FAST : TERM_SLOW));
  assign in_beep = (cur == BEEP_ON) || (cur == BEEP_OFF);

  // Terminal checks look at the post-tick count so that a phase lasts
  // exactly N tick periods rather than N periods plus one cycle.
  assign phase_inc    = phase + PH_W'(1);
  assign timeout_inc  = timeout + TO_W'(1);
  assign timeout_done = (timeout >= SIL_T) || (tick && (timeout_inc >= SIL_T));
  assign blink_inc    = blink + BL_W'(1);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cur      <= IDLE;
      buzzer   <= 1'b0;
      presc    <= '0;
      phase    <= '0;
      timeout  <= '0;
      tone_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + PRE_W'(1);
      if (tick)
        phase <= phase_inc;
      if (tick && in_beep && (timeout < SIL_T))
        timeout <= timeout_inc;

      case (cur)
        IDLE: begin
          buzzer <= 1'b0;
          if (alarm) begin
            cur      <= BEEP_ON;
            presc    <= '0;
            phase    <= '0;
            timeout  <= '0;
            tone_cnt <= '0;
          end
        end
        BEEP_ON: begin
          if (!alarm) begin
            cur    <= IDLE;
            buzzer <= 1'b0;
          end else if (ack || timeout_done) begin
            cur    <= SILENCED;
            buzzer <= 1'b0;
          end else if (tick && (phase_inc >= ON_T)) begin
            cur    <= BEEP_OFF;
            phase  <= '0;
            buzzer <= 1'b0;
          end else if (tone_cnt >= TONE_T) begin
            tone_cnt <= '0;
            buzzer   <= ~buzzer;
          end else begin
            tone_cnt <= tone_cnt + TN_W'(1);
          end
        end
        BEEP_OFF: begin
          buzzer <= 1'b0;
          if (!alarm) begin
            cur <= IDLE;
          end else if (ack || timeout_done) begin
            cur <= SILENCED;
          end else if (tick && (phase_inc >= OFF_T)) begin
            cur      <= BEEP_ON;
            phase    <= '0;
            tone_cnt <= '0;
          end
        end
        SILENCED: begin
          buzzer <= 1'b0;
          if (!alarm)
            cur <= IDLE;
        end
        default: begin
          cur    <= IDLE;
          buzzer <= 1'b0;
        end
      endcase
    end
  end

  // Display blink runs off the shared cadence tick, independent of the FSM.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      display_on <= 1'b1;
      blink      <= '0;
    end else if (!flash_req) begin
      display_on <= 1'b1;
      blink      <= '0;
    end else if (tick) begin
      if (blink_inc >= FLASH_T) begin
        display_on <= ~display_on;
        blink      <= '0;
      end else begin
        blink <= blink_inc;
      end
    end
  end

endmodule

// File: tb/tb_alarm_annunciator.sv
module tb_alarm_annunciator;

  logic       clk = 1'b0;
  logic       reset_b = 1'b1;
  logic       alarm = 1'b0;
  logic       flash_req = 1'b0;
  logic       ack = 1'b0;
  logic       fast = 1'b0;
  logic       buzzer;
  logic       display_on;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  alarm_annunciator #(
    .TONE_DIV       (2),
    .CADENCE_DIV    (10),
    .BEEP_ON_TICKS  (3),
    .BEEP_OFF_TICKS (2),
    .SILENCE_TICKS  (20),
    .FLASH_TICKS    (2)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .alarm      (alarm),
    .flash_req  (flash_req),
    .ack        (ack),
    .fast       (fast),
    .buzzer     (buzzer),
    .display_on (display_on),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at a falling edge with reset released; the next rising
  // edge is the first active one.
  task automatic apply_reset();
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_reset();
    alarm = 0; flash_req = 0; ack = 0; fast = 0;
    reset_b = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b want=%b", state, 2'b00); end
    checks++;
    if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got=%b want=0", buzzer); end
    checks++;
    if (display_on !== 1'b1) begin errors++; $display("FAIL reset_display got=%b want=1", display_on); end
    @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic test_beep_cadence();
    logic exp_b;
    alarm = 0; flash_req = 0; ack = 0; fast = 0;
    apply_reset();
    alarm = 1;
    step(1);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL cad_entry state got=%b want=01", state); end
    for (int k = 1; k < 30; k++) begin
      step(1);
      exp_b = ((k / 2) % 2) != 0;
      checks++;
      if (buzzer !== exp_b || state !== 2'b01) begin
        errors++;
        $display("FAIL cad_on k=%0d buzzer got=%b want=%b state got=%b want=01", k, buzzer, exp_b, state);
      end
    end
    step(1);
    checks++;
    if (state !== 2'b10 || buzzer !== 1'b0) begin
      errors++; $display("FAIL cad_to_off state got=%b want=10 buzzer got=%b want=0", state, buzzer);
    end
    for (int k = 31; k < 50; k++) begin
      step(1);
      checks++;
      if (state !== 2'b10 || buzzer !== 1'b0) begin
        errors++; $display("FAIL cad_off k=%0d state got=%b want=10 buzzer got=%b want=0", k, state, buzzer);
      end
    end
    step(1);
    checks++;
    if (state !== 2'b01 || buzzer !== 1'b0) begin
      errors++; $display("FAIL cad_reentry state got=%b want=01 buzzer got=%b want=0", state, buzzer);
    end
    step(2);
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL cad_reentry_tone buzzer got=%b want=1", buzzer); end
    alarm = 0;
    step(1);
    checks++;
    if (state !== 2'b00 || buzzer !== 1'b0) begin
      errors++; $display("FAIL cad_drop state got=%b want=00 buzzer got=%b want=0", state, buzzer);
    end
  endtask

  task automatic test_ack();
    alarm = 0; flash_req = 0; ack = 0; fast = 0;
    apply_reset();
    alarm = 1;
    step(1);
    step(7);
    ack = 1;
    step(1);
    ack = 0;
    checks++;
    if (state !== 2'b11 || buzzer !== 1'b0) begin
      errors++; $display("FAIL ack_silence state got=%b want=11 buzzer got=%b want=0", state, buzzer);
    end
    step(3);
    ack = 1;
    step(1);
    ack = 0;
    checks++;
    if (state !== 2'b11) begin errors++; $display("FAIL ack_ignored state got=%b want=11", state); end
    for (int k = 0; k < 10; k++) begin
      step(1);
      checks++;
      if (state !== 2'b11 || buzzer !== 1'b0) begin
        errors++; $display("FAIL ack_hold k=%0d state got=%b want=11 buzzer got=%b want=0", k, state, buzzer);
      end
    end
    alarm = 0;
    step(1);
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL ack_release state got=%b want=00", state); end
  endtask

  task automatic test_timeout();
    alarm = 0; flash_req = 0; ack = 0; fast = 0;
    apply_reset();
    alarm = 1;
    step(1);
    step(199);
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL to_before state got=%b want=10", state); end
    step(1);
    checks++;
    if (state !== 2'b11 || buzzer !== 1'b0) begin
      errors++; $display("FAIL to_silence state got=%b want=11 buzzer got=%b want=0", state, buzzer);
    end
    for (int k = 0; k < 30; k++) begin
      step(1);
      checks++;
      if (state !== 2'b11 || buzzer !== 1'b0) begin
        errors++; $display("FAIL to_hold k=%0d state got=%b want=11 buzzer got=%b want=0", k, state, buzzer);
      end
    end
    alarm = 0;
    step(1);
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL to_release state got=%b want=00", state); end
  endtask

  task automatic test_flash();
    alarm = 0; flash_req = 1; ack = 0; fast = 0;
    apply_reset();
    step(19);
    checks++;
    if (display_on !== 1'b1) begin errors++; $display("FAIL flash_p19 got=%b want=1", display_on); end
    step(1);
    checks++;
    if (display_on !== 1'b0) begin errors++; $display("FAIL flash_p20 got=%b want=0", display_on); end
    step(19);
    checks++;
    if (display_on !== 1'b0) begin errors++; $display("FAIL flash_p39 got=%b want=0", display_on); end
    step(1);
    checks++;
    if (display_on !== 1'b1) begin errors++; $display("FAIL flash_p40 got=%b want=1", display_on); end
    step(20);
    checks++;
    if (display_on !== 1'b0) begin errors++; $display("FAIL flash_p60 got=%b want=0", display_on); end
    step(5);
    flash_req = 0;
    step(1);
    checks++;
    if (display_on !== 1'b1) begin errors++; $display("FAIL flash_drop got=%b want=1", display_on); end
  endtask

  task automatic test_fast();
    alarm = 0; flash_req = 0; ack = 0; fast = 1;
    apply_reset();
    alarm = 1;
    step(1);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL fast_entry state got=%b want=01", state); end
    step(14);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL fast_on14 state got=%b want=01", state); end
    step(1);
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL fast_on15 state got=%b want=10", state); end
    step(9);
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL fast_off9 state got=%b want=10", state); end
    step(1);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL fast_off10 state got=%b want=01", state); end
    alarm = 0;
    fast = 0;
    step(1);
  endtask

  task automatic test_simultaneous();
    alarm = 0; flash_req = 0; ack = 0; fast = 0;
    apply_reset();
    alarm = 1;
    step(1);
    step(29);
    ack = 1;
    step(1);
    ack = 0;
    checks++;
    if (state !== 2'b11 || buzzer !== 1'b0) begin
      errors++; $display("FAIL sim_ack_phase state got=%b want=11 buzzer got=%b want=0", state, buzzer);
    end
    alarm = 0;
    apply_reset();
    alarm = 1;
    step(1);
    step(4);
    alarm = 0;
    ack = 1;
    step(1);
    ack = 0;
    checks++;
    if (state !== 2'b00 || buzzer !== 1'b0) begin
      errors++; $display("FAIL sim_drop_ack state got=%b want=00 buzzer got=%b want=0", state, buzzer);
    end
  endtask

  task automatic test_reset_mid();
    alarm = 0; flash_req = 1; ack = 0; fast = 0;
    apply_reset();
    step(20);
    checks++;
    if (display_on !== 1'b0) begin errors++; $display("FAIL rmid_flash got=%b want=0", display_on); end
    alarm = 1;
    step(1);
    step(3);
    checks++;
    if (state !== 2'b01 || buzzer !== 1'b1) begin
      errors++; $display("FAIL rmid_pre state got=%b want=01 buzzer got=%b want=1", state, buzzer);
    end
    #2;
    reset_b = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || buzzer !== 1'b0 || display_on !== 1'b1) begin
      errors++;
      $display("FAIL rmid_async state got=%b want=00 buzzer got=%b want=0 display got=%b want=1", state, buzzer, display_on);
    end
    reset_b = 1'b1;
    step(1);
    checks++;
    if (state !== 2'b01 || buzzer !== 1'b0 || display_on !== 1'b1) begin
      errors++;
      $display("FAIL rmid_release state got=%b want=01 buzzer got=%b want=0 display got=%b want=1", state, buzzer, display_on);
    end
    step(2);
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL rmid_tone buzzer got=%b want=1", buzzer); end
    alarm = 0;
    flash_req = 0;
    step(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beep_cadence();
    test_ack();
    test_timeout();
    test_flash();
    test_fast();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
